// File: rtl/spike_out_encoder_pkg.sv
// Shared constants, packet types and FSM encoding for the spike output encoder.
// Also provides a coordinate pack helper for SPIKE payloads.
package spike_out_encoder_pkg;

    localparam int NNW = 12;
    localparam int SW  = 24;
    localparam int CW  = SW / 3;
    localparam int FTW = 3;
    localparam int FD  = 8;
    localparam int FAW = 3;

    localparam logic [FTW-1:0] PKT_SPIKE    = 3'b000;
    localparam logic [FTW-1:0] PKT_DATA     = 3'b001;
    localparam logic [FTW-1:0] PKT_DATA_END = 3'b010;
    localparam logic [FTW-1:0] PKT_WRITE    = 3'b011;
    localparam logic [FTW-1:0] PKT_READ     = 3'b100;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND_SPK,
        ST_DUMP_RD,
        ST_DUMP_WAIT,
        ST_DUMP_SEND
    } enc_state_t;

    function automatic logic [SW-1:0] pack_coord(
        input logic [CW-1:0] z,
        input logic [CW-1:0] y,
        input logic [CW-1:0] x
    );
        return {z, y, x};
    endfunction

endpackage

// File: rtl/spike_out_encoder_fifo.sv
// Fire FIFO: FD entries of SW bits with a registered read port that always
// holds the entry that will be at the head on the next cycle.
module spike_fifo
    import spike_out_encoder_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    input  logic           push,
    input  logic [SW-1:0]  push_data,
    input  logic           pop,
    output logic [SW-1:0]  rd_data,
    output logic           full,
    output logic           empty,
    output logic [FAW:0]   count
);

    logic [SW-1:0]  mem [FD];
    logic [FAW-1:0] wr_ptr_reg;
    logic [FAW-1:0] rd_ptr_reg;
    logic [FAW-1:0] rd_ptr_next;
    logic [FAW:0]   count_reg;
    logic           push_ok;
    logic           pop_ok;

    assign full        = (count_reg == (FAW+1)'(FD));
    assign empty       = (count_reg == '0);
    assign count       = count_reg;
    assign pop_ok      = pop && !empty;
    // A full FIFO still takes a push when an entry leaves in the same cycle.
    assign push_ok     = push && (!full || pop_ok);
    assign rd_ptr_next = pop_ok ? rd_ptr_reg + 1'b1 : rd_ptr_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            rd_ptr_reg <= rd_ptr_next;
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Bypass covers the write landing on the slot that becomes the head.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr_reg] <= push_data;
        rd_data <= (push_ok && (wr_ptr_reg == rd_ptr_next)) ? push_data : mem[rd_ptr_next];
    end

endmodule

// File: rtl/spike_out_encoder.sv
// Node output encoder: turns soma fire flags into SPIKE packets and streams
// soma memory as DATA/DATA_END trains, behind a ready/valid output register.
module spike_out_encoder
    import spike_out_encoder_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            soma_fire_vld,
    input  logic            soma_fire,
    input  logic            soma_scan_first,
    output logic            enc_full,
    output logic            enc_ovf,
    input  logic [NNW-1:0]  x_out,
    input  logic [NNW-1:0]  y_out,
    input  logic [CW-1:0]   x_base,
    input  logic [CW-1:0]   y_base,
    input  logic            dump_req,
    input  logic [NNW-1:0]  dump_len,
    output logic            dump_done,
    output logic            enc_soma_re,
    output logic [NNW-1:0]  enc_soma_raddr,
    input  logic [SW-1:0]   soma_enc_rdata,
    output logic            spk_out_vld,
    input  logic            spk_out_rdy,
    output logic [SW-1:0]   spk_out_data,
    output logic [FTW-1:0]  spk_out_type
);

    logic [NNW-1:0] x_reg, y_reg, cur_x, cur_y, x_next, y_next;
    logic [CW-1:0]  z_reg, cur_z, z_next;
    logic           fire_push;
    logic [SW-1:0]  fire_data;

    logic [SW-1:0]  fifo_rdata;
    logic           fifo_full, fifo_empty, fifo_pop;
    logic [FAW:0]   fifo_count;

    enc_state_t     state_reg;
    logic           vld_reg, re_reg, done_reg, ovf_reg;
    logic [SW-1:0]  data_reg;
    logic [FTW-1:0] type_reg;
    logic [NNW-1:0] addr_reg, len_reg;

    // A scan-first neuron is (0,0,0) regardless of where the counters stand.
    always_comb begin
        cur_x  = soma_scan_first ? '0 : x_reg;
        cur_y  = soma_scan_first ? '0 : y_reg;
        cur_z  = soma_scan_first ? '0 : z_reg;
        x_next = cur_x + 1'b1;
        y_next = cur_y;
        z_next = cur_z;
        if (cur_x == x_out - 1'b1) begin
            x_next = '0;
            if (cur_y == y_out - 1'b1) begin
                y_next = '0;
                z_next = cur_z + 1'b1;
            end else begin
                y_next = cur_y + 1'b1;
            end
        end
    end

    assign fire_push = soma_fire_vld && soma_fire;
    assign fire_data = pack_coord(cur_z, cur_y[CW-1:0] + y_base, cur_x[CW-1:0] + x_base);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_reg   <= '0;
            y_reg   <= '0;
            z_reg   <= '0;
            ovf_reg <= 1'b0;
        end else begin
            if (soma_fire_vld) begin
                x_reg <= x_next;
                y_reg <= y_next;
                z_reg <= z_next;
            end
            if (fire_push && fifo_full && !fifo_pop) ovf_reg <= 1'b1;
        end
    end

    assign fifo_pop = !fifo_empty &&
                      ((state_reg == ST_IDLE) ||
                       (state_reg == ST_SEND_SPK && vld_reg && spk_out_rdy));

    spike_fifo u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fire_push),
        .push_data (fire_data),
        .pop       (fifo_pop),
        .rd_data   (fifo_rdata),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            vld_reg   <= 1'b0;
            data_reg  <= '0;
            type_reg  <= '0;
            re_reg    <= 1'b0;
            done_reg  <= 1'b0;
            addr_reg  <= '0;
            len_reg   <= '0;
        end else begin
            re_reg   <= 1'b0;
            done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        data_reg  <= fifo_rdata;
                        type_reg  <= PKT_SPIKE;
                        vld_reg   <= 1'b1;
                        state_reg <= ST_SEND_SPK;
                    end else if (dump_req) begin
                        len_reg <= dump_len;
                        if (dump_len != '0) begin
                            addr_reg  <= '0;
                            re_reg    <= 1'b1;
                            state_reg <= ST_DUMP_RD;
                        end else begin
                            done_reg <= 1'b1;
                        end
                    end
                end
                ST_SEND_SPK: begin
                    if (vld_reg && spk_out_rdy) begin
                        if (!fifo_empty) begin
                            data_reg <= fifo_rdata;
                        end else begin
                            vld_reg   <= 1'b0;
                            state_reg <= ST_IDLE;
                        end
                    end
                end
                ST_DUMP_RD: begin
                    state_reg <= ST_DUMP_WAIT;
                end
                ST_DUMP_WAIT: begin
                    data_reg  <= soma_enc_rdata;
                    type_reg  <= (addr_reg == len_reg - 1'b1) ? PKT_DATA_END : PKT_DATA;
                    vld_reg   <= 1'b1;
                    state_reg <= ST_DUMP_SEND;
                end
                ST_DUMP_SEND: begin
                    if (spk_out_rdy) begin
                        vld_reg <= 1'b0;
                        if (type_reg == PKT_DATA_END) begin
                            done_reg  <= 1'b1;
                            state_reg <= ST_IDLE;
                        end else begin
                            addr_reg  <= addr_reg + 1'b1;
                            re_reg    <= 1'b1;
                            state_reg <= ST_DUMP_RD;
                        end
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign enc_full       = (fifo_count == (FAW+1)'(FD));
    assign enc_ovf        = ovf_reg;
    assign dump_done      = done_reg;
    assign enc_soma_re    = re_reg;
    assign enc_soma_raddr = addr_reg;
    assign spk_out_vld    = vld_reg;
    assign spk_out_data   = data_reg;
    assign spk_out_type   = type_reg;

endmodule

// File: tb/tb_spike_out_encoder.sv
// Self-checking bench for spike_out_encoder: vector table of single-fire scans,
// then overflow, dump, priority, zero-length and reset sequences.
`timescale 1ns/1ps
module tb_spike_out_encoder;

    localparam int NNW = 12;
    localparam int SW  = 24;
    localparam int CW  = 8;
    localparam int FTW = 3;
    localparam logic [FTW-1:0] T_SPIKE = 3'b000;
    localparam logic [FTW-1:0] T_DATA  = 3'b001;
    localparam logic [FTW-1:0] T_END   = 3'b010;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           soma_fire_vld, soma_fire, soma_scan_first;
    logic           enc_full, enc_ovf;
    logic [NNW-1:0] x_out, y_out;
    logic [CW-1:0]  x_base, y_base;
    logic           dump_req;
    logic [NNW-1:0] dump_len;
    logic           dump_done, enc_soma_re;
    logic [NNW-1:0] enc_soma_raddr;
    logic [SW-1:0]  soma_enc_rdata;
    logic           spk_out_vld, spk_out_rdy;
    logic [SW-1:0]  spk_out_data;
    logic [FTW-1:0] spk_out_type;

    spike_out_encoder dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .soma_fire_vld   (soma_fire_vld),
        .soma_fire       (soma_fire),
        .soma_scan_first (soma_scan_first),
        .enc_full        (enc_full),
        .enc_ovf         (enc_ovf),
        .x_out           (x_out),
        .y_out           (y_out),
        .x_base          (x_base),
        .y_base          (y_base),
        .dump_req        (dump_req),
        .dump_len        (dump_len),
        .dump_done       (dump_done),
        .enc_soma_re     (enc_soma_re),
        .enc_soma_raddr  (enc_soma_raddr),
        .soma_enc_rdata  (soma_enc_rdata),
        .spk_out_vld     (spk_out_vld),
        .spk_out_rdy     (spk_out_rdy),
        .spk_out_data    (spk_out_data),
        .spk_out_type    (spk_out_type)
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        logic [FTW-1:0] typ;
        logic [SW-1:0]  data;
    } pkt_t;

    typedef struct {
        int             nscan;
        int             fire_idx;
        logic [CW-1:0]  xb;
        logic [CW-1:0]  yb;
        logic [SW-1:0]  exp;
    } vec_t;

    pkt_t           sb[$];
    logic [NNW-1:0] reads[$];
    logic [SW-1:0]  soma_mem [16];
    int             checks = 0;
    int             failures = 0;
    int             done_cnt = 0;
    int             rdy_mode = 1;
    int             npkt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_pkt(input logic [FTW-1:0] typ, input logic [SW-1:0] data);
        pkt_t p;
        p.typ  = typ;
        p.data = data;
        sb.push_back(p);
    endtask

    // Expected SPIKE payload of neuron i in raster order from the scan start.
    function automatic logic [SW-1:0] model(input int i);
        int xo, yo, x, y, z;
        logic [CW-1:0] xs, ys, zs;
        xo = int'(x_out);
        yo = int'(y_out);
        x  = i % xo;
        y  = (i / xo) % yo;
        z  = i / (xo * yo);
        xs = CW'(x + int'(x_base));
        ys = CW'(y + int'(y_base));
        zs = CW'(z);
        return {zs, ys, xs};
    endfunction

    task automatic drive_neuron(input logic first, input logic fire);
        soma_fire_vld   = 1'b1;
        soma_scan_first = first;
        soma_fire       = fire;
        tick();
        soma_fire_vld   = 1'b0;
        soma_scan_first = 1'b0;
        soma_fire       = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int c;
        c = 0;
        while (sb.size() != 0 && c < budget) begin
            tick();
            c++;
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL %s_drain actual=%0d_pending required=0", name, sb.size());
            sb.delete();
        end
        repeat (3) tick();
    endtask

    task automatic start_dump(input string name, input logic [NNW-1:0] len, input int budget);
        int c, n0;
        c  = 0;
        n0 = reads.size();
        dump_len = len;
        dump_req = 1'b1;
        while (reads.size() == n0 && c < budget) begin
            tick();
            c++;
        end
        dump_req = 1'b0;
        checks++;
        if (reads.size() == n0) begin
            failures++;
            $display("FAIL %s_start actual=no_read required=read", name);
        end
    endtask

    // Output monitor: scoreboard compare on handshake, hold check while stalled.
    logic           prev_stall = 1'b0;
    logic [SW-1:0]  prev_data;
    logic [FTW-1:0] prev_type;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                checks++;
                if (!spk_out_vld || spk_out_data !== prev_data || spk_out_type !== prev_type) begin
                    failures++;
                    $display("FAIL hold actual=vld%0b/%h/%0d required=vld1/%h/%0d",
                             spk_out_vld, spk_out_data, spk_out_type, prev_data, prev_type);
                end
            end
            if (spk_out_vld && spk_out_rdy) begin
                pkt_t e;
                checks++;
                npkt++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_pkt actual=%0d/%h required=none", spk_out_type, spk_out_data);
                end else begin
                    e = sb.pop_front();
                    if (spk_out_type !== e.typ || spk_out_data !== e.data) begin
                        failures++;
                        $display("FAIL pkt actual=%0d/%h required=%0d/%h",
                                 spk_out_type, spk_out_data, e.typ, e.data);
                    end else begin
                        $display("pkt %0d type=%0d data=%h", npkt, spk_out_type, spk_out_data);
                    end
                end
            end
            prev_stall = spk_out_vld && !spk_out_rdy;
            prev_data  = spk_out_data;
            prev_type  = spk_out_type;
            if (dump_done) done_cnt++;
            if (enc_soma_re) reads.push_back(enc_soma_raddr);
        end
    end

    // Soma memory: data appears one cycle after the read enable.
    initial begin
        logic           pend;
        logic [NNW-1:0] a;
        soma_enc_rdata = '0;
        forever begin
            @(negedge clk);
            pend = rst_n && enc_soma_re;
            a    = enc_soma_raddr;
            @(posedge clk);
            #1;
            if (pend) soma_enc_rdata = soma_mem[a[3:0]];
        end
    end

    initial begin
        spk_out_rdy = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       spk_out_rdy = 1'b0;
                1:       spk_out_rdy = 1'b1;
                default: spk_out_rdy = 1'($urandom_range(0, 1));
            endcase
        end
    end

    vec_t vecs[7];

    initial begin
        rst_n = 1'b0;
        soma_fire_vld = 1'b0; soma_fire = 1'b0; soma_scan_first = 1'b0;
        x_out = 12'd4; y_out = 12'd3; x_base = 8'd8; y_base = 8'd16;
        dump_req = 1'b0; dump_len = '0;
        for (int i = 0; i < 16; i++) soma_mem[i] = 24'(i * 24'h010101);
        soma_mem[0] = 24'h00000A; soma_mem[1] = 24'h00000B; soma_mem[2] = 24'h00000C;

        vecs[0] = '{12,  6,   8,  16, 24'h00110A};
        vecs[1] = '{24, 13,   8,  16, 24'h011009};
        vecs[2] = '{12,  0,   8,  16, 24'h001008};
        vecs[3] = '{12, 11,   8,  16, 24'h00120B};
        vecs[4] = '{24, 23,   8,  16, 24'h01120B};
        vecs[5] = '{12,  3,   8,  16, 24'h00100B};
        vecs[6] = '{12,  7, 250,   0, 24'h0001FD};

        repeat (3) tick();
        chk("rst_vld",  32'(spk_out_vld), 0);
        chk("rst_data", 32'(spk_out_data), 0);
        chk("rst_type", 32'(spk_out_type), 0);
        chk("rst_full", 32'(enc_full), 0);
        chk("rst_ovf",  32'(enc_ovf), 0);
        chk("rst_re",   32'(enc_soma_re), 0);
        chk("rst_done", 32'(dump_done), 0);
        rst_n = 1'b1;
        tick();

        // Single-fire scans
        rdy_mode = 1;
        for (int v = 0; v < 7; v++) begin
            x_base = vecs[v].xb;
            y_base = vecs[v].yb;
            exp_pkt(T_SPIKE, vecs[v].exp);
            for (int i = 0; i < vecs[v].nscan; i++)
                drive_neuron(i == 0, i == vecs[v].fire_idx);
            wait_drain($sformatf("vec%0d", v), 50);
        end
        x_base = 8'd8;
        y_base = 8'd16;

        // Overflow: one fire sits in the output register, 8 fill the FIFO, the 10th drops
        rdy_mode = 0;
        repeat (2) tick();
        for (int i = 0; i < 10; i++) begin
            if (i < 9) exp_pkt(T_SPIKE, model(i));
            drive_neuron(i == 0, 1'b1);
            if (i == 8) begin
                chk("full_at_8", 32'(enc_full), 1);
                chk("ovf_before_drop", 32'(enc_ovf), 0);
            end
        end
        chk("ovf_after_drop", 32'(enc_ovf), 1);
        repeat (5) tick();
        rdy_mode = 1;
        wait_drain("ovf", 60);
        chk("full_after_drain", 32'(enc_full), 0);
        exp_pkt(T_SPIKE, model(10));
        drive_neuron(1'b0, 1'b1);
        wait_drain("ovf_advance", 30);
        chk("ovf_sticky", 32'(enc_ovf), 1);

        // Dump of 3 words under random backpressure; dump_len change mid-dump ignored
        rdy_mode = 2;
        reads.delete();
        done_cnt = 0;
        exp_pkt(T_DATA, 24'h00000A);
        exp_pkt(T_DATA, 24'h00000B);
        exp_pkt(T_END,  24'h00000C);
        start_dump("dump3", 12'd3, 20);
        dump_len = 12'd1;
        wait_drain("dump3", 200);
        chk("dump3_reads", 32'(reads.size()), 3);
        for (int i = 0; i < 3 && i < reads.size(); i++)
            chk($sformatf("dump3_raddr%0d", i), 32'(reads[i]), 32'(i));
        chk("dump3_done", 32'(done_cnt), 1);

        // Queued spikes go before a simultaneous dump; a mid-dump fire waits for DATA_END
        rdy_mode = 0;
        reads.delete();
        done_cnt = 0;
        repeat (2) tick();
        exp_pkt(T_SPIKE, model(1));
        exp_pkt(T_SPIKE, model(2));
        for (int i = 0; i < 3; i++) drive_neuron(i == 0, i != 0);
        exp_pkt(T_DATA, 24'h00000A);
        exp_pkt(T_END,  24'h00000B);
        exp_pkt(T_SPIKE, model(0));
        rdy_mode = 2;
        start_dump("prio", 12'd2, 60);
        drive_neuron(1'b1, 1'b1);
        wait_drain("prio", 200);
        chk("prio_reads", 32'(reads.size()), 2);
        chk("prio_done", 32'(done_cnt), 1);

        // Zero-length dump: done pulse, no packets
        rdy_mode = 1;
        done_cnt = 0;
        npkt = 0;
        dump_len = '0;
        dump_req = 1'b1;
        tick();
        dump_req = 1'b0;
        repeat (4) tick();
        chk("len0_done", 32'(done_cnt), 1);
        chk("len0_pkts", 32'(npkt), 0);

        // Reset while a DATA word is stalled on the output
        rdy_mode = 0;
        reads.delete();
        soma_mem[0] = 24'h123456;
        soma_mem[1] = 24'h654321;
        start_dump("rst", 12'd3, 20);
        begin
            int c;
            c = 0;
            while (!spk_out_vld && c < 20) begin
                tick();
                c++;
            end
        end
        chk("rst_mid_vld_before", 32'(spk_out_vld), 1);
        chk("rst_mid_ovf_before", 32'(enc_ovf), 1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_vld", 32'(spk_out_vld), 0);
        chk("rst_mid_re",  32'(enc_soma_re), 0);
        chk("rst_mid_ovf", 32'(enc_ovf), 0);
        tick();
        rst_n = 1'b1;
        tick();
        rdy_mode = 1;
        reads.delete();
        done_cnt = 0;
        exp_pkt(T_DATA, 24'h123456);
        exp_pkt(T_END,  24'h654321);
        start_dump("restart", 12'd2, 20);
        wait_drain("restart", 60);
        chk("restart_raddr0", (reads.size() > 0) ? 32'(reads[0]) : 32'hFFFF, 0);
        chk("restart_done", 32'(done_cnt), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
